// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - fetch-to-decode instruction FIFO with flush and rdy freeze
// Optional zero-latency empty-queue bypass: INST_QUEUE_BYPASS_EN.
module inst_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [INST_W-1:0]        out_inst,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     wp_q, wp_d;
    logic [PW-1:0]     rp_q, rp_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [ADDR_W-1:0] pc_mem_d   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [INST_W-1:0] inst_mem_d [DEPTH];

    logic empty;
    logic full;
    logic bypass;
    logic push;
    logic pop;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));
`ifdef INST_QUEUE_BYPASS_EN
        bypass = empty & in_valid & rdy & ~flush;
`else
        bypass = 1'b0;
`endif
        // in_ready depends only on registered occupancy, never on out_ready
        in_ready  = ~full;
        out_valid = ~empty | bypass;
        out_pc    = '0;
        out_inst  = '0;
        if (!empty) begin
            out_pc   = pc_mem_q[rp_q];
            out_inst = inst_mem_q[rp_q];
        end
`ifdef INST_QUEUE_BYPASS_EN
        else if (bypass) begin
            out_pc   = in_pc;
            out_inst = in_inst;
        end
`endif
        // A bypassed instruction consumed in the same cycle is never stored
        push = rdy & in_valid & ~full & ~flush & ~(bypass & out_ready);
        pop  = rdy & ~empty & out_ready & ~flush;
    end

    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        if (rst || flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_mem_d[wp_q]   = in_pc;
                inst_mem_d[wp_q] = in_inst;
                wp_d             = wp_q + PW'(1);
            end
            if (pop) begin
                rp_d = rp_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        wp_q       <= wp_d;
        rp_q       <= rp_d;
        count_q    <= count_d;
        pc_mem_q   <= pc_mem_d;
        inst_mem_q <= inst_mem_d;
    end

    assign count = count_q;

endmodule
